vproc_vreg_wr_arb: RTL and testbench
====================================

VPROC_VREG_WR_ARB -- requirements
Module: vproc_vreg_wr_arb

Interface
REQ-001 SHALL have parameter REQ_CNT, default 2, number of write requesters (legal 1..4).
REQ-002 SHALL have parameter PORT_W, default 128, write data width in bits (multiple of 8).
REQ-003 SHALL have parameter ADDR_W, default 5, vector register address width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port async_rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  REQ_CNT  per-requester write request valid.
REQ-007 SHALL have port req_ready_o  output  REQ_CNT  per-requester accept.
REQ-008 SHALL have port req_addr_i  input  REQ_CNT x ADDR_W  target vreg per requester.
REQ-009 SHALL have port req_data_i  input  REQ_CNT x PORT_W  write data per requester.
REQ-010 SHALL have port req_be_i  input  REQ_CNT x PORT_W/8  byte enables per requester.
REQ-011 SHALL have port wr_we_o  output  1  register-file write enable.
REQ-012 SHALL have port wr_addr_o  output  ADDR_W  register-file write address.
REQ-013 SHALL have port wr_data_o  output  PORT_W  register-file write data.
REQ-014 SHALL have port wr_be_o  output  PORT_W/8  register-file byte enables.
REQ-015 SHALL have port pend_o  output  2^ADDR_W  one-hot-OR mask of vregs with accepted, uncommitted writes.

Function
REQ-016 SHALL hold one 2-entry FIFO per requester storing {addr, data, be}.
REQ-017 SHALL drive req_ready_o[k] = 1 iff FIFO k holds fewer than 2 entries (registered count only; no dependence on same-cycle pop).
REQ-018 SHALL push into FIFO k on rising edge where req_valid_i[k] & req_ready_o[k].
REQ-019 SHALL, each cycle, grant at most one non-empty FIFO by round-robin: first non-empty index starting at pointer rr, wrapping modulo REQ_CNT.
REQ-020 SHALL, on a grant g, pop FIFO g head and advance rr to (g+1) mod REQ_CNT; rr unchanged when no grant.
REQ-021 SHALL register the granted head into the output stage: wr_we_o=1 with its addr/data/be during the following cycle; wr_we_o=0 when no grant.
REQ-022 SHALL give uncontended latency of 2 edges: accepted at edge E0, wr_we_o high in the cycle after edge E1.
REQ-023 SHALL treat the register file as never stalling; one entry drains per cycle total.
REQ-024 SHALL permit simultaneous push and pop on the same FIFO; count unchanged, order preserved.
REQ-025 SHALL preserve per-requester write order; no ordering guarantee across requesters.
REQ-026 SHALL pass wr_be_o unmodified, including all-zero be (wr_we_o still asserted).
REQ-027 SHALL compute pend_o combinationally as OR of decoded addresses of all valid FIFO entries and the output stage when wr_we_o=1.
REQ-028 SHALL keep pend_o bit set while any entry for that vreg remains, even if multiple requesters target it.
REQ-029 SHALL hold wr_addr_o/wr_data_o/wr_be_o stable (last value) when wr_we_o=0.

Reset
REQ-030 SHALL, on async_rst_ni=0, immediately clear all FIFOs, set rr=0, wr_we_o=0, wr_addr_o=0, wr_data_o=0, wr_be_o=0.
REQ-031 SHALL, in reset, drive req_ready_o all 1 and pend_o all 0.
REQ-032 SHALL discard in-flight entries on reset assertion mid-operation; no write issued after release until new requests accepted.

Verification
REQ-033 SHALL cover: single request k=0 addr=3 data=0xA5.. be=all-1 at edge E0 -> wr_we_o=1 addr=3 after E1; pend_o[3]=1 from after E0 until wr_we_o drops.
REQ-034 SHALL cover: both requesters valid every cycle, REQ_CNT=2 -> grants alternate 0,1,0,1; each req_ready_o drops after 2 unpopped pushes, sustained throughput 1 write/cycle.
REQ-035 SHALL cover: requester 1 pushes addr 7 then 8 while requester 0 idle -> writes 7 then 8 on consecutive cycles, order kept.
REQ-036 SHALL cover: full FIFO with same-cycle pop and valid -> req_ready_o=0 that cycle, push rejected, count goes 2->1.
REQ-037 SHALL cover: both requesters target addr 5 -> pend_o[5] stays 1 until second write issued, then clears.
REQ-038 SHALL cover: reset asserted with 3 entries queued -> outputs zero immediately, no wr_we_o after release, pend_o=0.

Source files
------------

// File: rtl/vproc_vreg_wr_arb.sv
// Vector register-file write arbiter: per-requester 2-entry FIFOs, round-robin
// grant into a single registered write port, and a pending-write vreg mask.
module vproc_vreg_wr_arb #(
    parameter int REQ_CNT = 2,
    parameter int PORT_W  = 128,
    parameter int ADDR_W  = 5
) (
    input  logic                                clk_i,
    input  logic                                async_rst_ni,

    input  logic [REQ_CNT-1:0]                  req_valid_i,
    output logic [REQ_CNT-1:0]                  req_ready_o,
    input  logic [REQ_CNT-1:0][ADDR_W-1:0]      req_addr_i,
    input  logic [REQ_CNT-1:0][PORT_W-1:0]      req_data_i,
    input  logic [REQ_CNT-1:0][PORT_W/8-1:0]    req_be_i,

    output logic                                wr_we_o,
    output logic [ADDR_W-1:0]                   wr_addr_o,
    output logic [PORT_W-1:0]                   wr_data_o,
    output logic [PORT_W/8-1:0]                 wr_be_o,

    output logic [(1<<ADDR_W)-1:0]              pend_o
);

    localparam int BE_W = PORT_W / 8;
    localparam int RR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    // Handshake: a requester's entry is taken on a rising edge where
    // req_valid_i[k] & req_ready_o[k]; ready depends only on the registered
    // FIFO occupancy, never on a same-cycle pop, so it carries no comb path.

    logic [ADDR_W-1:0] fifo_addr_q [REQ_CNT][2];
    logic [PORT_W-1:0] fifo_data_q [REQ_CNT][2];
    logic [BE_W-1:0]   fifo_be_q   [REQ_CNT][2];

    logic [1:0]        cnt_q    [REQ_CNT];
    logic [1:0]        cnt_d    [REQ_CNT];
    logic              rd_ptr_q [REQ_CNT];
    logic              rd_ptr_d [REQ_CNT];
    logic              wr_ptr_q [REQ_CNT];
    logic              wr_ptr_d [REQ_CNT];

    logic [REQ_CNT-1:0] push;
    logic [REQ_CNT-1:0] pop;
    logic [REQ_CNT-1:0] not_empty;

    logic [RR_W-1:0]   rr_q, rr_d;
    logic              gnt_valid;
    logic [RR_W-1:0]   gnt_idx;

    logic              wr_we_q,   wr_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PORT_W-1:0] wr_data_q, wr_data_d;
    logic [BE_W-1:0]   wr_be_q,   wr_be_d;

    function automatic logic [RR_W-1:0] wrap_idx(input logic [RR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= REQ_CNT) s = s - REQ_CNT;
        return RR_W'(s);
    endfunction

    always_comb begin
        for (int k = 0; k < REQ_CNT; k++) begin
            req_ready_o[k] = (cnt_q[k] != 2'd2);
            not_empty[k]   = (cnt_q[k] != 2'd0);
            push[k]        = req_valid_i[k] & req_ready_o[k];
        end
    end

    // Scan from the highest offset down so the closest non-empty index wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int off = REQ_CNT - 1; off >= 0; off--) begin
            if (not_empty[wrap_idx(rr_q, off)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = wrap_idx(rr_q, off);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_valid) rr_d = wrap_idx(gnt_idx, 1);
        for (int k = 0; k < REQ_CNT; k++) begin
            pop[k] = gnt_valid && (gnt_idx == RR_W'(k));
        end
    end

    always_comb begin
        for (int k = 0; k < REQ_CNT; k++) begin
            cnt_d[k]    = cnt_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            wr_ptr_d[k] = wr_ptr_q[k];
            if (push[k]) wr_ptr_d[k] = ~wr_ptr_q[k];
            if (pop[k])  rd_ptr_d[k] = ~rd_ptr_q[k];
            if (push[k] && !pop[k]) cnt_d[k] = cnt_q[k] + 2'd1;
            if (!push[k] && pop[k]) cnt_d[k] = cnt_q[k] - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            for (int k = 0; k < REQ_CNT; k++) begin
                cnt_q[k]    <= 2'd0;
                rd_ptr_q[k] <= 1'b0;
                wr_ptr_q[k] <= 1'b0;
            end
            rr_q <= '0;
        end else begin
            for (int k = 0; k < REQ_CNT; k++) begin
                cnt_q[k]    <= cnt_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                wr_ptr_q[k] <= wr_ptr_d[k];
            end
            rr_q <= rr_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < REQ_CNT; k++) begin
            if (push[k]) begin
                fifo_addr_q[k][wr_ptr_q[k]] <= req_addr_i[k];
                fifo_data_q[k][wr_ptr_q[k]] <= req_data_i[k];
                fifo_be_q[k][wr_ptr_q[k]]   <= req_be_i[k];
            end
        end
    end

    always_comb begin
        wr_we_d   = gnt_valid;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_be_d   = wr_be_q;
        if (gnt_valid) begin
            wr_addr_d = fifo_addr_q[gnt_idx][rd_ptr_q[gnt_idx]];
            wr_data_d = fifo_data_q[gnt_idx][rd_ptr_q[gnt_idx]];
            wr_be_d   = fifo_be_q[gnt_idx][rd_ptr_q[gnt_idx]];
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            wr_we_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
        end else begin
            wr_we_q   <= wr_we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_be_q   <= wr_be_d;
        end
    end

    assign wr_we_o   = wr_we_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign wr_be_o   = wr_be_q;

    // With two slots, a full FIFO holds both; otherwise only the head is live.
    always_comb begin
        pend_o = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            if (cnt_q[k] != 2'd0) pend_o[fifo_addr_q[k][rd_ptr_q[k]]]  = 1'b1;
            if (cnt_q[k] == 2'd2) pend_o[fifo_addr_q[k][~rd_ptr_q[k]]] = 1'b1;
        end
        if (wr_we_q) pend_o[wr_addr_q] = 1'b1;
    end

endmodule

// File: tb/tb_vproc_vreg_wr_arb.sv
// Bench for vproc_vreg_wr_arb: queue-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_vproc_vreg_wr_arb;

    localparam int REQ_CNT = 2;
    localparam int PORT_W  = 128;
    localparam int ADDR_W  = 5;
    localparam int BE_W    = PORT_W / 8;
    localparam int NV      = 1 << ADDR_W;

    logic                              clk;
    logic                              rst_n;
    logic [REQ_CNT-1:0]                req_valid;
    logic [REQ_CNT-1:0]                req_ready;
    logic [REQ_CNT-1:0][ADDR_W-1:0]    req_addr;
    logic [REQ_CNT-1:0][PORT_W-1:0]    req_data;
    logic [REQ_CNT-1:0][BE_W-1:0]      req_be;
    logic                              wr_we;
    logic [ADDR_W-1:0]                 wr_addr;
    logic [PORT_W-1:0]                 wr_data;
    logic [BE_W-1:0]                   wr_be;
    logic [NV-1:0]                     pend;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    vproc_vreg_wr_arb #(
        .REQ_CNT(REQ_CNT),
        .PORT_W (PORT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i       (clk),
        .async_rst_ni(rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_be_i    (req_be),
        .wr_we_o     (wr_we),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .wr_be_o     (wr_be),
        .pend_o      (pend)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [PORT_W-1:0] d;
        logic [BE_W-1:0]   b;
    } ent_t;

    ent_t mf   [REQ_CNT][2];
    int   mcnt [REQ_CNT];
    int   mrr;
    bit   m_we;
    ent_t m_out;

    always @(posedge clk or negedge rst_n) begin
        int g;
        bit rdy [REQ_CNT];
        if (!rst_n) begin
            for (int k = 0; k < REQ_CNT; k++) mcnt[k] = 0;
            mrr   = 0;
            m_we  = 1'b0;
            m_out = '0;
        end else begin
            for (int k = 0; k < REQ_CNT; k++) rdy[k] = (mcnt[k] < 2);
            g = -1;
            for (int off = 0; off < REQ_CNT; off++) begin
                if (g < 0 && mcnt[(mrr + off) % REQ_CNT] > 0) g = (mrr + off) % REQ_CNT;
            end
            if (g >= 0) begin
                m_out    = mf[g][0];
                mf[g][0] = mf[g][1];
                mcnt[g]  = mcnt[g] - 1;
                m_we     = 1'b1;
                mrr      = (g + 1) % REQ_CNT;
            end else begin
                m_we = 1'b0;
            end
            for (int k = 0; k < REQ_CNT; k++) begin
                if (req_valid[k] && rdy[k]) begin
                    mf[k][mcnt[k]] = {req_addr[k], req_data[k], req_be[k]};
                    mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    end

    function automatic logic [NV-1:0] model_pend();
        logic [NV-1:0] m;
        m = '0;
        for (int k = 0; k < REQ_CNT; k++)
            for (int i = 0; i < mcnt[k]; i++) m[mf[k][i].a] = 1'b1;
        if (m_we) m[m_out.a] = 1'b1;
        return m;
    endfunction

    function automatic logic [REQ_CNT-1:0] model_ready();
        logic [REQ_CNT-1:0] r;
        for (int k = 0; k < REQ_CNT; k++) r[k] = (mcnt[k] < 2);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [PORT_W-1:0] act, input logic [PORT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_we",    PORT_W'(wr_we),     PORT_W'(m_we));
            chk("m_addr",  PORT_W'(wr_addr),   PORT_W'(m_out.a));
            chk("m_data",  wr_data,            m_out.d);
            chk("m_be",    PORT_W'(wr_be),     PORT_W'(m_out.b));
            chk("m_pend",  PORT_W'(pend),      PORT_W'(model_pend()));
            chk("m_ready", PORT_W'(req_ready), PORT_W'(model_ready()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input logic [ADDR_W-1:0] a,
                           input logic [PORT_W-1:0] d, input logic [BE_W-1:0] b);
        req_valid[k] = v;
        req_addr[k]  = a;
        req_data[k]  = d;
        req_be[k]    = b;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [PORT_W-1:0] a5;
        logic [PORT_W-1:0] rd;
        a5 = {16{8'hA5}};

        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_be    = '0;
        repeat (2) step();
        chk("rst_we",    PORT_W'(wr_we), '0);
        chk("rst_ready", PORT_W'(req_ready), PORT_W'(2'b11));
        chk("rst_pend",  PORT_W'(pend), '0);
        chk("rst_data",  wr_data, '0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        // single request, latency and pend lifetime
        set_req(0, 1'b1, 5'd3, a5, '1);
        step();
        chk("s_pend3_e0", PORT_W'(pend[3]), 1);
        chk("s_we_e0",    PORT_W'(wr_we), 0);
        req_valid = '0;
        step();
        chk("s_we_e1",   PORT_W'(wr_we), 1);
        chk("s_addr_e1", PORT_W'(wr_addr), 3);
        chk("s_data_e1", wr_data, a5);
        chk("s_be_e1",   PORT_W'(wr_be), PORT_W'(16'hFFFF));
        chk("s_pend_e1", PORT_W'(pend), PORT_W'(32'h8));
        step();
        chk("s_we_e2",   PORT_W'(wr_we), 0);
        chk("s_pend_e2", PORT_W'(pend), 0);
        chk("s_hold",    wr_data, a5);

        // requester 1 alone, order kept
        set_req(1, 1'b1, 5'd7, 128'h7, 16'h00FF);
        step();
        set_req(1, 1'b1, 5'd8, 128'h8, 16'h0000);
        step();
        chk("o_we7",   PORT_W'(wr_we), 1);
        chk("o_addr7", PORT_W'(wr_addr), 7);
        req_valid = '0;
        step();
        chk("o_we8",   PORT_W'(wr_we), 1);
        chk("o_addr8", PORT_W'(wr_addr), 8);
        chk("o_be0",   PORT_W'(wr_be), 0);
        step();
        chk("o_idle",  PORT_W'(wr_we), 0);

        // both target vreg 5
        set_req(0, 1'b1, 5'd5, 128'h50, '1);
        set_req(1, 1'b1, 5'd5, 128'h51, '1);
        step();
        chk("p_e0", PORT_W'(pend), PORT_W'(32'h20));
        req_valid = '0;
        step();
        chk("p_e1",    PORT_W'(pend), PORT_W'(32'h20));
        chk("p_we_e1", PORT_W'(wr_we), 1);
        step();
        chk("p_e2",    PORT_W'(pend), PORT_W'(32'h20));
        chk("p_we_e2", PORT_W'(wr_we), 1);
        step();
        chk("p_e3",    PORT_W'(pend), 0);

        // saturation from rr=0: alternating grants, full-FIFO push rejection
        do_reset();
        set_req(0, 1'b1, 5'd0, 128'hA, '1);
        set_req(1, 1'b1, 5'd1, 128'hB, '1);
        step();
        chk("t_ready_e0", PORT_W'(req_ready), PORT_W'(2'b11));
        step();
        chk("t_addr_e1",  PORT_W'(wr_addr), 0);
        chk("t_ready_e1", PORT_W'(req_ready), PORT_W'(2'b01));
        for (int i = 1; i < 8; i++) begin
            step();
            chk("t_we",   PORT_W'(wr_we), 1);
            chk("t_addr", PORT_W'(wr_addr), PORT_W'(i % 2));
        end
        idle(5);

        // reset with three entries queued plus one in the output stage
        set_req(0, 1'b1, 5'd9,  128'h9, '1);
        set_req(1, 1'b1, 5'd10, 128'h10, '1);
        step();
        step();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("r_we",    PORT_W'(wr_we), 0);
        chk("r_addr",  PORT_W'(wr_addr), 0);
        chk("r_data",  wr_data, 0);
        chk("r_be",    PORT_W'(wr_be), 0);
        chk("r_pend",  PORT_W'(pend), 0);
        chk("r_ready", PORT_W'(req_ready), PORT_W'(2'b11));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r_post_we",   PORT_W'(wr_we), 0);
            chk("r_post_pend", PORT_W'(pend), 0);
        end

        // randomized traffic, with one reset in the middle
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < REQ_CNT; k++) begin
                rd = {$urandom(), $urandom(), $urandom(), $urandom()};
                set_req(k, ($urandom_range(0, 99) < 60),
                        ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom_range(0, NV - 1)),
                        rd,
                        ($urandom_range(0, 9) == 0) ? '0 : BE_W'($urandom()));
            end
            if (c == 400) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
